// File: rtl/inv_shiftrows.sv
// inv_shiftrows: byte-serial AES InvShiftRows stage with two ping-pong banks.
//   clock, reset           rising-edge clock, async active-high reset
//   inbyte/in_valid/in_ready     column-major input bytes (k = row k%4, col k/4)
//   outbyte/out_valid/out_ready  row-shifted output bytes, same order
//   out_last               marks the 16th byte of each output block
//   STEP                   read stride mod 16 (13 = InvShiftRows, 5 = ShiftRows)
module inv_shiftrows #(
    parameter int STEP = 13
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] inbyte,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] outbyte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last
);
    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_t;
    bank_st_t   st_q [2];
    bank_st_t   st_d [2];
    logic [7:0] mem [2][16];
    logic [3:0] wp, k, ra;
    logic       wb, rb, wr, rd;
    assign in_ready  = st_q[wb] == EMPTY || st_q[wb] == FILLING;
    assign out_valid = st_q[rb] == FULL || st_q[rb] == DRAINING;
    assign wr        = in_valid && in_ready;
    assign rd        = out_valid && out_ready;
    // Stepping the read index by STEP mod 16 walks the column-major state so
    // that each row r picks up its bytes rotated by r columns.
    assign ra        = 4'(STEP * int'(k));
    assign outbyte   = out_valid ? mem[rb][ra] : 8'h00;
    assign out_last  = out_valid && k == 4'd15;
    // wr and rd always target different banks, since a bank is never both
    // writable and readable, so the two updates below cannot collide.
    always_comb begin
        st_d[0] = st_q[0];
        st_d[1] = st_q[1];
        if (wr) st_d[wb] = wp == 4'd15 ? FULL : FILLING;
        if (rd) st_d[rb] = k == 4'd15 ? EMPTY : DRAINING;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_q[0] <= EMPTY;
            st_q[1] <= EMPTY;
            wp      <= 4'd0;
            k       <= 4'd0;
            wb      <= 1'b0;
            rb      <= 1'b0;
        end else begin
            st_q[0] <= st_d[0];
            st_q[1] <= st_d[1];
            if (wr) begin
                wp <= wp + 4'd1;
                wb <= wp == 4'd15 ? ~wb : wb;
            end
            if (rd) begin
                k  <= k + 4'd1;
                rb <= k == 4'd15 ? ~rb : rb;
            end
        end
    end
    always_ff @(posedge clock) begin
        if (wr) mem[wb][wp] <= inbyte;
    end
endmodule

// File: tb/tb_inv_shiftrows.sv
// tb_inv_shiftrows: self-checking bench for inv_shiftrows.
//   dut            STEP=13 instance under directed and random traffic
//   lb_a -> lb_b   STEP=5 feeding STEP=13, output must equal input
module tb_inv_shiftrows;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] inbyte, outbyte;
    logic       in_valid, in_ready, out_valid, out_ready, out_last;
    logic [7:0] lb_inbyte, mid_byte, lb_outbyte;
    logic       lb_in_valid, lb_in_ready, mid_valid, mid_ready, mid_last;
    logic       lb_out_valid, lb_out_ready, lb_out_last;
    int         total = 0;
    int         bad = 0;

    always #5 clock = ~clock;

    inv_shiftrows dut (
        .clock(clock), .reset(reset), .inbyte(inbyte), .in_valid(in_valid),
        .in_ready(in_ready), .outbyte(outbyte), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last)
    );
    inv_shiftrows #(.STEP(5)) lb_a (
        .clock(clock), .reset(reset), .inbyte(lb_inbyte), .in_valid(lb_in_valid),
        .in_ready(lb_in_ready), .outbyte(mid_byte), .out_valid(mid_valid),
        .out_ready(mid_ready), .out_last(mid_last)
    );
    inv_shiftrows #(.STEP(13)) lb_b (
        .clock(clock), .reset(reset), .inbyte(mid_byte), .in_valid(mid_valid),
        .in_ready(mid_ready), .outbyte(lb_outbyte), .out_valid(lb_out_valid),
        .out_ready(lb_out_ready), .out_last(lb_out_last)
    );

    // InvShiftRows by definition: out[row r, col c] = in[row r, col (c - r) mod 4].
    function automatic int isr_src(int n);
        int r = n % 4;
        int c = n / 4;
        return r + 4 * ((c - r + 4) % 4);
    endfunction

    task automatic do_reset();
        in_valid = 0; inbyte = 0; out_ready = 0;
        lb_in_valid = 0; lb_inbyte = 0; lb_out_ready = 0;
        reset = 1;
        repeat (2) @(negedge clock);
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
        total++; if (outbyte !== 8'h00) begin bad++; $display("FAIL reset_outbyte got=%h want=00", outbyte); end
    endtask

    task automatic test_single(input bit do_rst);
        int acc = 0, got = 0, acc_cyc = -1, first_v = -1;
        logic [7:0] e;
        if (do_rst) do_reset();
        out_ready = 1;
        for (int c = 0; c < 80 && got < 16; c++) begin
            if (out_valid) begin
                if (first_v < 0) first_v = c;
                e = 8'(isr_src(got));
                total++; if (outbyte !== e) begin bad++; $display("FAIL single_byte%0d got=%h want=%h", got, outbyte, e); end
                total++; if (out_last !== 1'(got == 15)) begin bad++; $display("FAIL single_last%0d got=%b want=%b", got, out_last, got == 15); end
                got++;
            end
            in_valid = acc < 16;
            inbyte = 8'(acc);
            if (in_valid && in_ready) begin
                if (acc == 15) acc_cyc = c;
                acc++;
            end
            @(negedge clock);
        end
        in_valid = 0;
        out_ready = 0;
        total++; if (got != 16) begin bad++; $display("FAIL single_count got=%0d want=16", got); end
        total++; if (first_v != acc_cyc + 1) begin bad++; $display("FAIL single_latency got=%0d want=%0d", first_v, acc_cyc + 1); end
    endtask

    task automatic test_back_to_back();
        int acc = 0, got = 0, first_v = -1;
        logic [7:0] e;
        do_reset();
        out_ready = 1;
        for (int c = 0; c < 120 && got < 32; c++) begin
            if (first_v >= 0) begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_contig%0d got=%b want=1", got, out_valid); end
            end
            if (out_valid) begin
                if (first_v < 0) first_v = c;
                e = 8'(16 * (got / 16) + isr_src(got % 16));
                total++; if (outbyte !== e) begin bad++; $display("FAIL b2b_byte%0d got=%h want=%h", got, outbyte, e); end
                total++; if (out_last !== 1'(got % 16 == 15)) begin bad++; $display("FAIL b2b_last%0d got=%b want=%b", got, out_last, got % 16 == 15); end
                got++;
            end
            in_valid = acc < 32;
            inbyte = 8'(acc);
            if (in_valid) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready%0d got=%b want=1", acc, in_ready); end
                if (in_ready) acc++;
            end
            @(negedge clock);
        end
        in_valid = 0;
        total++; if (got != 32) begin bad++; $display("FAIL b2b_count got=%0d want=32", got); end
    endtask

    task automatic test_backpressure();
        int acc = 0, got = 0;
        bit rise_chk = 0;
        logic [7:0] e;
        do_reset();
        out_ready = 0;
        for (int c = 0; c < 40; c++) begin
            total++; if (in_ready !== 1'(acc < 32)) begin bad++; $display("FAIL bp_in_ready acc=%0d got=%b want=%b", acc, in_ready, acc < 32); end
            if (acc >= 16) begin
                total++; if (out_valid !== 1'b1 || outbyte !== 8'h00 || out_last !== 1'b0) begin
                    bad++; $display("FAIL bp_hold got=v%b/%h/l%b want=v1/00/l0", out_valid, outbyte, out_last);
                end
            end
            in_valid = acc < 48;
            inbyte = 8'(acc);
            if (in_valid && in_ready) acc++;
            @(negedge clock);
        end
        total++; if (acc != 32) begin bad++; $display("FAIL bp_accepted got=%0d want=32", acc); end
        out_ready = 1;
        for (int c = 0; c < 200 && got < 48; c++) begin
            if (got == 16 && !rise_chk) begin
                rise_chk = 1;
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_rise got=%b want=1", in_ready); end
            end
            if (out_valid) begin
                e = 8'(16 * (got / 16) + isr_src(got % 16));
                total++; if (outbyte !== e) begin bad++; $display("FAIL bp_byte%0d got=%h want=%h", got, outbyte, e); end
                got++;
            end
            in_valid = acc < 48;
            inbyte = 8'(acc);
            if (in_valid && in_ready) acc++;
            @(negedge clock);
        end
        in_valid = 0;
        repeat (3) @(negedge clock);
        total++; if (got != 48) begin bad++; $display("FAIL bp_count got=%0d want=48", got); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_extra got=%b want=0", out_valid); end
        out_ready = 0;
    endtask

    task automatic test_gapped();
        logic [7:0] src [1600];
        logic [7:0] e, prev_byte;
        logic prev_last;
        bit stall = 0;
        int acc = 0, got = 0;
        do_reset();
        for (int i = 0; i < 1600; i++) src[i] = 8'($urandom);
        for (int c = 0; c < 20000 && got < 1600; c++) begin
            if (stall) begin
                total++; if (out_valid !== 1'b1 || outbyte !== prev_byte || out_last !== prev_last) begin
                    bad++; $display("FAIL gap_stable got=v%b/%h/l%b want=v1/%h/l%b", out_valid, outbyte, out_last, prev_byte, prev_last);
                end
            end
            out_ready = 1'($urandom_range(1));
            if (out_valid && out_ready) begin
                e = src[16 * (got / 16) + isr_src(got % 16)];
                total++; if (outbyte !== e || out_last !== 1'(got % 16 == 15)) begin
                    bad++; $display("FAIL gap_byte%0d got=%h/l%b want=%h/l%b", got, outbyte, out_last, e, got % 16 == 15);
                end
                got++;
            end
            stall = out_valid && !out_ready;
            prev_byte = outbyte;
            prev_last = out_last;
            in_valid = acc < 1600 && 1'($urandom_range(1));
            inbyte = acc < 1600 ? src[acc] : 8'h00;
            if (in_valid && in_ready) acc++;
            @(negedge clock);
        end
        in_valid = 0;
        out_ready = 0;
        total++; if (got != 1600) begin bad++; $display("FAIL gap_count got=%0d want=1600", got); end
    endtask

    task automatic test_reset_mid();
        int acc = 0, got = 0;
        do_reset();
        for (int c = 0; c < 100 && !(acc == 23 && got == 3); c++) begin
            in_valid = acc < 23;
            inbyte = 8'(acc + 8'h40);
            out_ready = got < 3;
            if (out_valid && out_ready) got++;
            if (in_valid && in_ready) acc++;
            @(negedge clock);
        end
        in_valid = 0;
        out_ready = 0;
        total++; if (acc != 23 || got != 3) begin bad++; $display("FAIL mid_setup got=%0d/%0d want=23/3", acc, got); end
        reset = 1;
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL mid_async got=v%b r%b want=v0 r1", out_valid, in_ready);
        end
        total++; if (outbyte !== 8'h00 || out_last !== 1'b0) begin
            bad++; $display("FAIL mid_async_out got=%h/l%b want=00/l0", outbyte, out_last);
        end
        @(negedge clock);
        reset = 0;
        test_single(0);
    endtask

    task automatic test_loopback();
        logic [7:0] src [320];
        int acc = 0, got = 0, lasts = 0;
        do_reset();
        for (int i = 0; i < 320; i++) src[i] = 8'($urandom);
        for (int c = 0; c < 5000 && got < 320; c++) begin
            lb_out_ready = $urandom_range(9) < 7;
            if (lb_out_valid && lb_out_ready) begin
                total++; if (lb_outbyte !== src[got] || lb_out_last !== 1'(got % 16 == 15)) begin
                    bad++; $display("FAIL loop_byte%0d got=%h/l%b want=%h/l%b", got, lb_outbyte, lb_out_last, src[got], got % 16 == 15);
                end
                got++;
            end
            if (mid_valid && mid_ready && mid_last) lasts++;
            lb_in_valid = acc < 320 && $urandom_range(9) < 7;
            lb_inbyte = acc < 320 ? src[acc] : 8'h00;
            if (lb_in_valid && lb_in_ready) acc++;
            @(negedge clock);
        end
        lb_in_valid = 0;
        lb_out_ready = 0;
        total++; if (got != 320) begin bad++; $display("FAIL loop_count got=%0d want=320", got); end
        total++; if (lasts != 20) begin bad++; $display("FAIL loop_mid_last got=%0d want=20", lasts); end
    endtask

    initial begin
        test_reset();
        test_single(1);
        test_back_to_back();
        test_backpressure();
        test_gapped();
        test_reset_mid();
        test_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
